// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, types and byte helpers for the calculator UART reporter.
// Contents: SYNC_BYTE, FRAME_BYTES, header bit positions, tx_state_t, calc_state_t,
// hdr_byte()/frame_byte() which build the four frame bytes from a snapshot.
// Optional feature macro CALC_UART_PARITY_EN is consumed by uart_tx_byte.
package calc_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 4;

    localparam int HDR_MODE_LSB = 6;
    localparam int HDR_OP_LSB   = 4;
    localparam int HDR_OVF_BIT  = 3;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} tx_state_t;

    typedef struct packed {
        logic [1:0] mode;
        logic [1:0] op;
        logic       ovf;
        logic [7:0] result;
    } calc_state_t;

    function automatic logic [7:0] hdr_byte(input calc_state_t s);
        hdr_byte = 8'h00;
        hdr_byte[HDR_MODE_LSB +: 2] = s.mode;
        hdr_byte[HDR_OP_LSB +: 2]   = s.op;
        hdr_byte[HDR_OVF_BIT]       = s.ovf;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input calc_state_t s);
        frame_byte = (idx == 2'd0) ? SYNC_BYTE :
                     (idx == 2'd1) ? hdr_byte(s) :
                     (idx == 2'd2) ? s.result :
                                     SYNC_BYTE ^ hdr_byte(s) ^ s.result;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: serialises one byte per start/done handshake (start, 8 data LSB first, stop).
// Ports: clk, rst_n (async active-low), start (load data and begin), data[7:0],
//        tx (serial line, idle high), done (pulse in the last cycle of the stop bit).
// A start accepted together with done chains the next byte with no idle gap.
// CALC_UART_PARITY_EN: inserts an even-parity bit between data bit 7 and stop.
module uart_tx_byte
    import calc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t   state;
    logic [BW-1:0] baud;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        tick;

    always_comb begin
        tick = baud == BW'(CLKS_PER_BIT - 1);
        done = (state == STOP) && tick;
        tx   = (state == START) ? 1'b0 :
               (state == DATA)  ? shift[bit_cnt] :
`ifdef CALC_UART_PARITY_EN
               (state == PARITY) ? ^shift :
`endif
               1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            baud <= (state == IDLE || tick) ? '0 : baud + BW'(1);
            case (state)
                IDLE: if (start) begin
                    state <= START;
                    shift <= data;
                end
                START: if (tick) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA: if (tick) begin
                    bit_cnt <= bit_cnt + 3'd1;
`ifdef CALC_UART_PARITY_EN
                    if (bit_cnt == 3'd7) state <= PARITY;
`else
                    if (bit_cnt == 3'd7) state <= STOP;
`endif
                end
`ifdef CALC_UART_PARITY_EN
                PARITY: if (tick) state <= STOP;
`endif
                STOP: if (tick) begin
                    state <= start ? START : IDLE;
                    if (start) shift <= data;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/calc_uart_reporter.sv
// calc_uart_reporter: reports the displayed calculator state to a host as a 4-byte UART frame.
// Frame: A5, {MODE,OPERATION,OVERFLOW,3'b000}, RESULT, XOR checksum of the three.
// Ports: CLK, RESET_N (async active-low), RESULT[7:0], MODE[1:0], OPERATION[1:0], OVERFLOW,
//        SEND (force a frame), TX (idle high), BUSY (frame in flight), FRAME_DONE (end pulse).
// A frame is sent after reset, on SEND, and whenever the inputs differ from the last snapshot.
// CALC_UART_PARITY_EN: adds an even-parity bit per byte (see uart_tx_byte).
module calc_uart_reporter
    import calc_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] RESULT,
    input  logic [1:0] MODE,
    input  logic [1:0] OPERATION,
    input  logic       OVERFLOW,
    input  logic       SEND,
    output logic       TX,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    calc_state_t cur, snap;
    logic        pending, busy, done, last, launch, byte_start;
    logic [1:0]  idx;
    logic [7:0]  byte_data;

    always_comb begin
        cur        = {MODE, OPERATION, OVERFLOW, RESULT};
        last       = idx == 2'(FRAME_BYTES - 1);
        launch     = !busy && pending;
        byte_start = launch || (done && !last);
        // SYNC needs no snapshot, so it can go out on the same edge the snapshot loads
        byte_data  = launch ? SYNC_BYTE : frame_byte(idx + 2'd1, snap);
        FRAME_DONE = done && last;
        BUSY       = busy;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            busy    <= 1'b0;
            pending <= 1'b1;
            snap    <= '0;
            idx     <= '0;
        end else if (launch) begin
            busy    <= 1'b1;
            pending <= 1'b0;
            snap    <= cur;
            idx     <= '0;
        end else begin
            if (done && last) busy <= 1'b0;
            if (done && !last) idx <= idx + 2'd1;
            if (SEND || cur != snap) pending <= 1'b1;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (CLK),
        .rst_n (RESET_N),
        .start (byte_start),
        .data  (byte_data),
        .tx    (TX),
        .done  (done)
    );

endmodule

// File: tb/tb_calc_uart_reporter.sv
// tb_calc_uart_reporter: directed self-checking bench for calc_uart_reporter at CLKS_PER_BIT=4.
module tb_calc_uart_reporter;

    localparam int CPB = 4;
`ifdef CALC_UART_PARITY_EN
    localparam int BPB = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int BPB = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FLEN = 4 * BPB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] result = 8'h00;
    logic [1:0] mode = 2'b00;
    logic [1:0] op = 2'b00;
    logic       ovf = 1'b0;
    logic       send = 1'b0;
    logic       tx, busy, fd;

    int total = 0;
    int bad = 0;

    logic tw [0:399];
    logic fw [0:399];
    logic bw [0:399];

    always #5 clk = ~clk;

    calc_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .RESULT     (result),
        .MODE       (mode),
        .OPERATION  (op),
        .OVERFLOW   (ovf),
        .SEND       (send),
        .TX         (tx),
        .BUSY       (busy),
        .FRAME_DONE (fd)
    );

    // Expected-waveform model: counts cycles from off whose TX differs from the ideal frame b
    // (b[31:24] is the first byte on the line).
    function automatic int wave_err(input int off, input logic [31:0] b);
        int e = 0;
        for (int i = 0; i < FLEN; i++) begin
            int slot = i / CPB;
            int k = slot / BPB;
            int p = slot % BPB;
            logic [7:0] v = b[31 - 8 * k -: 8];
            logic x = (p == 0) ? 1'b0 : (p <= 8) ? v[p - 1] : (PAR && p == 9) ? ^v : 1'b1;
            if (tw[off + i] !== x) e++;
        end
        return e;
    endfunction

    function automatic int count_fd(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (fw[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic wait_busy(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic capture(input int n, input int chg_at, input logic [7:0] chg_val, input int send_at);
        for (int i = 0; i < n; i++) begin
            tw[i] = tx;
            fw[i] = fd;
            bw[i] = busy;
            if (i == chg_at) result = chg_val;
            send = (i == send_at);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bit seen;
        int e;
        repeat (2) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (fd !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", fd); end
        rst_n = 1'b1;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL reset_start: got %b want 1", seen); end
        capture(FLEN + 2, -1, 8'h00, -1);
        e = wave_err(0, 32'hA5_00_00_A5);
        total++; if (e !== 0) begin bad++; $display("FAIL reset_frame: got %0d bad cycles want 0", e); end
        total++; if (fw[FLEN - 1] !== 1'b1 || count_fd(FLEN + 2) !== 1)
            begin bad++; $display("FAIL reset_done: got %b/%0d want 1/1", fw[FLEN - 1], count_fd(FLEN + 2)); end
        total++; if (bw[FLEN - 1] !== 1'b1 || bw[FLEN] !== 1'b0 || bw[FLEN + 1] !== 1'b0)
            begin bad++; $display("FAIL reset_busy_end: got %b%b%b want 100", bw[FLEN - 1], bw[FLEN], bw[FLEN + 1]); end
    endtask

    task automatic test_encode;
        bit seen;
        int e;
        mode = 2'b01; op = 2'b10; ovf = 1'b1; result = 8'h03;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL encode_start: got %b want 1", seen); end
        capture(FLEN + 2, -1, 8'h00, -1);
        e = wave_err(0, 32'hA5_68_03_CE);
        total++; if (e !== 0) begin bad++; $display("FAIL encode_frame: got %0d bad cycles want 0", e); end
        total++; if (fw[FLEN - 1] !== 1'b1 || bw[FLEN] !== 1'b0 || tw[FLEN] !== 1'b1)
            begin bad++; $display("FAIL encode_end: got fd=%b busy=%b tx=%b want 1 0 1", fw[FLEN - 1], bw[FLEN], tw[FLEN]); end
    endtask

    task automatic test_extreme;
        bit seen;
        int e;
        mode = 2'b11; op = 2'b11; ovf = 1'b1; result = 8'hFF;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL extreme_start: got %b want 1", seen); end
        capture(FLEN + 2, -1, 8'h00, -1);
        e = wave_err(0, 32'hA5_F8_FF_A2);
        total++; if (e !== 0) begin bad++; $display("FAIL extreme_frame: got %0d bad cycles want 0", e); end
    endtask

    task automatic test_mid_change;
        bit seen;
        int e;
        mode = 2'b00; op = 2'b00; ovf = 1'b0; result = 8'h0C;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_start: got %b want 1", seen); end
        capture(2 * FLEN + 2, 50, 8'h0D, -1);
        e = wave_err(0, 32'hA5_00_0C_A9);
        total++; if (e !== 0) begin bad++; $display("FAIL mid_frame1: got %0d bad cycles want 0", e); end
        total++; if (bw[FLEN] !== 1'b0 || tw[FLEN] !== 1'b1 || bw[FLEN + 1] !== 1'b1)
            begin bad++; $display("FAIL mid_gap: got busy=%b tx=%b next=%b want 0 1 1", bw[FLEN], tw[FLEN], bw[FLEN + 1]); end
        e = wave_err(FLEN + 1, 32'hA5_00_0D_A8);
        total++; if (e !== 0) begin bad++; $display("FAIL mid_frame2: got %0d bad cycles want 0", e); end
        total++; if (fw[2 * FLEN] !== 1'b1 || count_fd(2 * FLEN + 2) !== 2)
            begin bad++; $display("FAIL mid_done: got %b/%0d want 1/2", fw[2 * FLEN], count_fd(2 * FLEN + 2)); end
    endtask

    task automatic test_back_to_back;
        bit seen;
        int e;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL b2b_start: got %b want 1", seen); end
        capture(2 * FLEN + 2, -1, 8'h00, FLEN - 1);
        e = wave_err(0, 32'hA5_00_0D_A8);
        total++; if (e !== 0) begin bad++; $display("FAIL b2b_frame1: got %0d bad cycles want 0", e); end
        total++; if (bw[FLEN] !== 1'b0 || tw[FLEN] !== 1'b1 || bw[FLEN + 1] !== 1'b1)
            begin bad++; $display("FAIL b2b_gap: got busy=%b tx=%b next=%b want 0 1 1", bw[FLEN], tw[FLEN], bw[FLEN + 1]); end
        e = wave_err(FLEN + 1, 32'hA5_00_0D_A8);
        total++; if (e !== 0) begin bad++; $display("FAIL b2b_frame2: got %0d bad cycles want 0", e); end
        total++; if (bw[2 * FLEN + 1] !== 1'b0)
            begin bad++; $display("FAIL b2b_idle: got %b want 0", bw[2 * FLEN + 1]); end
    endtask

    task automatic test_reset_mid;
        bit seen;
        int e;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_busy(seen);
        capture(50, -1, 8'h00, -1);
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx !== 1'b1 || busy !== 1'b0 || fd !== 1'b0)
            begin bad++; $display("FAIL rstmid_async: got tx=%b busy=%b fd=%b want 1 0 0", tx, busy, fd); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rstmid_start: got %b want 1", seen); end
        capture(FLEN + 2, -1, 8'h00, -1);
        e = wave_err(0, 32'hA5_00_0D_A8);
        total++; if (e !== 0) begin bad++; $display("FAIL rstmid_frame: got %0d bad cycles want 0", e); end
        total++; if (fw[FLEN - 1] !== 1'b1 || bw[FLEN] !== 1'b0)
            begin bad++; $display("FAIL rstmid_end: got fd=%b busy=%b want 1 0", fw[FLEN - 1], bw[FLEN]); end
    endtask

`ifdef CALC_UART_PARITY_EN
    task automatic test_parity;
        bit seen;
        int e;
        mode = 2'b00; op = 2'b00; ovf = 1'b0; result = 8'h07;
        wait_busy(seen);
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL par_start: got %b want 1", seen); end
        capture(FLEN + 2, -1, 8'h00, -1);
        total++; if (tw[(2 * 11 + 9) * CPB + 1] !== 1'b1)
            begin bad++; $display("FAIL par_bit: got %b want 1", tw[(2 * 11 + 9) * CPB + 1]); end
        e = wave_err(0, 32'hA5_00_07_A2);
        total++; if (e !== 0) begin bad++; $display("FAIL par_frame: got %0d bad cycles want 0", e); end
        total++; if (fw[175] !== 1'b1 || bw[175] !== 1'b1 || bw[176] !== 1'b0)
            begin bad++; $display("FAIL par_len: got fd=%b busy=%b%b want 1 10", fw[175], bw[175], bw[176]); end
    endtask
`endif

    initial begin
        test_reset;
        test_encode;
        test_extreme;
        test_mid_change;
        test_back_to_back;
        test_reset_mid;
`ifdef CALC_UART_PARITY_EN
        test_parity;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
